match_encoder_32: RTL and testbench

Combinational 32-to-5 priority encoder with a one-cycle registered copy of its result. It converts the 32-bit per-entry match vector of a 32-entry associative table, such as the branch lookup table, into the index of the matching entry. The combinational result drives the same-cycle table read. The registered copy serves downstream pipeline stages.

---
 rtl/enc_pkg.sv | 10 +
 rtl/enc_prio8.sv | 29 ++
 rtl/match_encoder_32.sv | 62 ++++++
 tb/tb_match_encoder_32.sv | 134 +++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths for the 32-to-5 match encoder.
// Optional multi-hit detection is built when ENC_MULTI_HIT_EN is defined.
package enc_pkg;
  localparam int ENC_IN_W    = 32;
  localparam int ENC_IDX_W   = 5;
  localparam int SLICE_W     = 8;
  localparam int NUM_SLICES  = 4;
  localparam int SLICE_IDX_W = 3;
  localparam int SEL_W       = 2;
endpackage

// File: rtl/enc_prio8.sv
// 8-to-3 lowest-index-wins priority slice.
// Multi-hit output is live only when ENC_MULTI_HIT_EN is defined.
module enc_prio8
  import enc_pkg::*;
(
  input  logic [SLICE_W-1:0]     in,
  output logic [SLICE_IDX_W-1:0] idx,
  output logic                   any,
  output logic                   multi
);

  // Scan downward so the lowest set bit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = SLICE_W - 1; i >= 0; i--) begin
      if (in[i]) idx = SLICE_IDX_W'(i);
    end
  end

  assign any = |in;

`ifdef ENC_MULTI_HIT_EN
  // Clearing the lowest set bit leaves something iff two or more bits set.
  assign multi = |(in & (in - SLICE_W'(1)));
`else
  assign multi = 1'b0;
`endif

endmodule

// File: rtl/match_encoder_32.sv
// 32-to-5 priority encoder with a one-cycle registered copy.
// Multi-hit detection is built when ENC_MULTI_HIT_EN is defined.
module match_encoder_32
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ENC_IN_W-1:0]  in,
  output logic [ENC_IDX_W-1:0] out,
  output logic                 any,
  output logic                 multi,
  output logic [ENC_IDX_W-1:0] out_q,
  output logic                 any_q,
  output logic                 multi_q
);

  logic [SLICE_IDX_W-1:0] s_idx [NUM_SLICES];
  logic [NUM_SLICES-1:0]  s_any;
  logic [NUM_SLICES-1:0]  s_multi;
  logic [SEL_W-1:0]       sel;

  for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
    enc_prio8 u_slice (
      .in    (in[g*SLICE_W +: SLICE_W]),
      .idx   (s_idx[g]),
      .any   (s_any[g]),
      .multi (s_multi[g])
    );
  end

  always_comb begin
    sel = '0;
    for (int s = NUM_SLICES - 1; s >= 0; s--) begin
      if (s_any[s]) sel = SEL_W'(s);
    end
  end

  assign out = {sel, s_idx[sel]};
  assign any = |s_any;

`ifdef ENC_MULTI_HIT_EN
  // A hit spanning two slices is a multi-hit even if each slice has one bit.
  assign multi = (|s_multi) | (|(s_any & (s_any - NUM_SLICES'(1))));
`else
  logic multi_unused;
  assign multi_unused = |s_multi;
  assign multi        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      any_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      out_q   <= out;
      any_q   <= any;
      multi_q <= multi;
    end
  end

endmodule

// File: tb/tb_match_encoder_32.sv
// Scoreboard bench for match_encoder_32.
// Expected multi-hit values depend on ENC_MULTI_HIT_EN.
module tb_match_encoder_32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic [4:0]  out, out_q;
  logic        any, any_q, multi, multi_q;

  typedef struct {
    logic [4:0] e_out;
    logic       e_any;
    logic       e_multi;
    logic       rst;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  match_encoder_32 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .out     (out),
    .any     (any),
    .multi   (multi),
    .out_q   (out_q),
    .any_q   (any_q),
    .multi_q (multi_q)
  );

  always #5 clk = ~clk;

`ifdef ENC_MULTI_HIT_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (in=%h)", nm, act, req, in);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and log expectations.
  task automatic drive(input logic [31:0] v, input logic r,
                       input logic [4:0] eo, input logic ea,
                       input logic em);
    exp_t e;
    @(negedge clk);
    in    = v;
    reset = r;
    e.e_out   = eo;
    e.e_any   = ea;
    e.e_multi = em & MEN;
    e.rst     = r;
    sb.push_back(e);
  endtask

  // Monitor: comb outputs before the edge, registered outputs 1ns after.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out",   int'(out),   int'(e.e_out));
        chk("any",   int'(any),   int'(e.e_any));
        chk("multi", int'(multi), int'(e.e_multi));
        #1;
        chk("out_q",   int'(out_q),   e.rst ? 0 : int'(e.e_out));
        chk("any_q",   int'(any_q),   e.rst ? 0 : int'(e.e_any));
        chk("multi_q", int'(multi_q), e.rst ? 0 : int'(e.e_multi));
      end
    end
  end

  typedef struct {
    logic [31:0] v;
    logic [4:0]  o;
    logic        a;
    logic        m;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h0000_0014, 5'd2,  1'b1, 1'b1},
    '{32'h8000_0100, 5'd8,  1'b1, 1'b1},
    '{32'hFFFF_FFFF, 5'd0,  1'b1, 1'b1},
    '{32'h0000_0000, 5'd0,  1'b0, 1'b0},
    '{32'h0000_0100, 5'd8,  1'b1, 1'b0},
    '{32'h0001_0000, 5'd16, 1'b1, 1'b0},
    '{32'h0100_0000, 5'd24, 1'b1, 1'b0},
    '{32'h0000_0080, 5'd7,  1'b1, 1'b0},
    '{32'h8000_0000, 5'd31, 1'b1, 1'b0},
    '{32'h0000_0180, 5'd7,  1'b1, 1'b1}
  };

  initial begin
    int waited;
    reset = 1'b1;
    in    = 32'h0;
    drive(32'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(32'h0000_0001, 1'b1, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++)
      drive(32'h1 << i, 1'b0, 5'(i), 1'b1, 1'b0);
    foreach (vecs[k])
      drive(vecs[k].v, 1'b0, vecs[k].o, vecs[k].a, vecs[k].m);
    drive(32'h0004_0000, 1'b0, 5'd18, 1'b1, 1'b0);
    drive(32'h0004_0000, 1'b1, 5'd18, 1'b1, 1'b0);
    drive(32'h0004_0000, 1'b0, 5'd18, 1'b1, 1'b0);
    drive(32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0);
    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
